integrator_shutdown_sequencer: RTL and testbench
================================================

INTEGRATOR_SHUTDOWN_SEQUENCER -- requirements
Module: integrator_shutdown_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles dac_hold is asserted before power drops; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: request to arm the output stage.
REQ-005 SHALL have port setup_done, input, 1: threshold integrator ready.
REQ-006 SHALL have port over_threshold, input, 1: integrator threshold fault.
REQ-007 SHALL have port err_overflow, input, 1: integrator FIFO overflow.
REQ-008 SHALL have port err_underflow, input, 1: integrator FIFO underflow.
REQ-009 SHALL have port ext_shutdown, input, 1: external shutdown request.
REQ-010 SHALL have port fault_clear, input, 1: software acknowledge of a latched fault.
REQ-011 SHALL have ports armed, dac_hold, power_enable, fault; each output, 1; all registered.
REQ-012 SHALL have port fault_cause, output, 4: bit0 over_threshold, bit1 err_overflow, bit2 err_underflow, bit3 ext_shutdown.
REQ-013 SHALL have port fault_timestamp, output, 32: cycle count at trigger; present only with the macro in REQ-032.

Function
REQ-014 SHALL implement states IDLE, ARMING, ARMED, HOLD, SHUTDOWN.
REQ-015 IDLE: enable=1 -> ARMING next cycle; all outputs low.
REQ-016 ARMING: setup_done=1 with no fault input -> ARMED; enable=0 -> IDLE.
REQ-017 ARMED: armed=1, power_enable=1; both rise in the first ARMED cycle, i.e. one cycle after setup_done is sampled.
REQ-018 ARMED: enable=0 with no fault input -> IDLE; power_enable=0 and armed=0 next cycle; fault_cause unchanged (0).
REQ-019 Fault input = OR of over_threshold, err_overflow, err_underflow, ext_shutdown; sampled in ARMING and ARMED only; ignored in IDLE.
REQ-020 Fault sampled in ARMED at cycle N -> HOLD at N+1; dac_hold=1, armed=0 at N+1; power_enable stays 1.
REQ-021 HOLD lasts exactly HOLD_CYCLES cycles, then SHUTDOWN; down-counter loaded with HOLD_CYCLES-1 on entry.
REQ-022 Fault sampled in ARMING -> SHUTDOWN directly; HOLD skipped, since power was never enabled.
REQ-023 SHUTDOWN: fault=1, dac_hold=1, power_enable=0, armed=0.
REQ-024 fault_cause SHALL capture all sources asserted in the trigger cycle; simultaneous sources set multiple bits.
REQ-025 fault_cause SHALL hold its value; sources asserting after the trigger cycle are ignored.
REQ-026 enable, setup_done and further fault inputs SHALL be ignored in HOLD and SHUTDOWN.
REQ-027 SHUTDOWN exits to IDLE on fault_clear=1 only when all four fault inputs are 0 in the same cycle.
REQ-028 On that exit, fault, dac_hold and fault_cause clear on entering IDLE.
REQ-029 fault_clear SHALL be ignored in all other states, and in SHUTDOWN while any fault input is 1.

Reset
REQ-030 rst SHALL force IDLE; all outputs 0; hold counter 0; timestamp counter 0.
REQ-031 rst mid-HOLD or mid-SHUTDOWN SHALL drop dac_hold and fault immediately and asynchronously; no state is retained.

Configuration
REQ-032 Macro SHUTDOWN_TIMESTAMP_EN defined: a free-running 32-bit cycle counter runs from reset release and wraps 0xFFFFFFFF->0.
REQ-033 With the macro, the counter value in the trigger cycle latches into fault_timestamp, which clears under the same rule as fault_cause.
REQ-034 Macro undefined: no counter and no fault_timestamp port; all other behaviour identical.

Structure
REQ-035 Package integrator_shutdown_pkg SHALL hold the state encoding and the fault_cause bit-index constants.
REQ-036 No sub-module; the hold counter and timestamp counter are inline.

Verification
REQ-037 enable=1, setup_done after 5 cycles, over_threshold pulse in ARMED, HOLD_CYCLES=16 -> dac_hold next cycle; power_enable low exactly 16 cycles later; fault=1; fault_cause=4'b0001.
REQ-038 err_overflow and ext_shutdown asserted in the same cycle in ARMED -> fault_cause=4'b1010; a later err_underflow leaves it unchanged.
REQ-039 ext_shutdown in ARMING -> SHUTDOWN next cycle; dac_hold never precedes it; power_enable never 1.
REQ-040 In SHUTDOWN, fault_clear while over_threshold=1 -> stays SHUTDOWN; fault_clear after it drops -> IDLE; fault_cause=0.
REQ-041 rst asserted 3 cycles into HOLD -> all outputs 0 asynchronously; after release, a new enable rearms normally.
REQ-042 With SHUTDOWN_TIMESTAMP_EN, counter preloaded near wrap (force to 0xFFFFFFFE), trigger 3 cycles later -> fault_timestamp=0x00000001.

Source files
------------

// File: rtl/integrator_shutdown_sequencer_pkg.sv
// State encoding and fault_cause bit positions for the integrator shutdown sequencer.
package integrator_shutdown_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_SHUTDOWN = 3'd4
  } state_t;

  localparam int CAUSE_OVER_THRESHOLD = 0;
  localparam int CAUSE_ERR_OVERFLOW   = 1;
  localparam int CAUSE_ERR_UNDERFLOW  = 2;
  localparam int CAUSE_EXT_SHUTDOWN   = 3;
  localparam int CAUSE_W              = 4;

endpackage

// File: rtl/integrator_shutdown_sequencer_if.sv
// Control/status bundle between the integrator and the shutdown sequencer.
// fault_timestamp exists only when SHUTDOWN_TIMESTAMP_EN is defined.
interface integrator_shutdown_sequencer_if;
  import integrator_shutdown_pkg::*;

  logic               enable;
  logic               setup_done;
  logic               over_threshold;
  logic               err_overflow;
  logic               err_underflow;
  logic               ext_shutdown;
  logic               fault_clear;
  logic               armed;
  logic               dac_hold;
  logic               power_enable;
  logic               fault;
  logic [CAUSE_W-1:0] fault_cause;
`ifdef SHUTDOWN_TIMESTAMP_EN
  logic [31:0]        fault_timestamp;

  modport master (
    output enable, setup_done, over_threshold, err_overflow, err_underflow,
           ext_shutdown, fault_clear,
    input  armed, dac_hold, power_enable, fault, fault_cause, fault_timestamp
  );

  modport slave (
    input  enable, setup_done, over_threshold, err_overflow, err_underflow,
           ext_shutdown, fault_clear,
    output armed, dac_hold, power_enable, fault, fault_cause, fault_timestamp
  );
`else
  modport master (
    output enable, setup_done, over_threshold, err_overflow, err_underflow,
           ext_shutdown, fault_clear,
    input  armed, dac_hold, power_enable, fault, fault_cause
  );

  modport slave (
    input  enable, setup_done, over_threshold, err_overflow, err_underflow,
           ext_shutdown, fault_clear,
    output armed, dac_hold, power_enable, fault, fault_cause
  );
`endif

endinterface

// File: rtl/integrator_shutdown_sequencer.sv
// Arms the output stage and, on a fault, holds the DAC for HOLD_CYCLES before dropping power.
// Optional SHUTDOWN_TIMESTAMP_EN adds a free-running cycle counter latched at the fault trigger.
module integrator_shutdown_sequencer
  import integrator_shutdown_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input logic                         clk,
  input logic                         rst,
  integrator_shutdown_sequencer_if.slave io
);

  state_t             state, state_nxt;
  logic [15:0]        hold_cnt, hold_cnt_nxt;
  logic [CAUSE_W-1:0] cause_q, cause_nxt;
  logic [CAUSE_W-1:0] src;
  logic               fault_in;
  logic               capture;
  logic               clear;
  logic               armed_q, dac_hold_q, power_q, fault_q;

  always_comb begin
    src                       = '0;
    src[CAUSE_OVER_THRESHOLD] = io.over_threshold;
    src[CAUSE_ERR_OVERFLOW]   = io.err_overflow;
    src[CAUSE_ERR_UNDERFLOW]  = io.err_underflow;
    src[CAUSE_EXT_SHUTDOWN]   = io.ext_shutdown;
  end

  assign fault_in = |src;

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    cause_nxt    = cause_q;
    capture      = 1'b0;
    clear        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (io.enable) state_nxt = ST_ARMING;
      end
      ST_ARMING: begin
        // Power was never enabled here, so there is nothing to hold.
        if (fault_in) begin
          state_nxt = ST_SHUTDOWN;
          capture   = 1'b1;
        end else if (io.setup_done) begin
          state_nxt = ST_ARMED;
        end else if (!io.enable) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (fault_in) begin
          state_nxt    = ST_HOLD;
          capture      = 1'b1;
          hold_cnt_nxt = 16'(HOLD_CYCLES - 1);
        end else if (!io.enable) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == 16'd0) state_nxt = ST_SHUTDOWN;
        else                   hold_cnt_nxt = hold_cnt - 16'd1;
      end
      ST_SHUTDOWN: begin
        if (io.fault_clear && !fault_in) begin
          state_nxt = ST_IDLE;
          clear     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (capture) cause_nxt = src;
    if (clear)   cause_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      cause_q    <= '0;
      armed_q    <= 1'b0;
      dac_hold_q <= 1'b0;
      power_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      cause_q    <= cause_nxt;
      // Outputs are decoded from the next state so they change with the state flop.
      armed_q    <= (state_nxt == ST_ARMED);
      dac_hold_q <= (state_nxt == ST_HOLD) || (state_nxt == ST_SHUTDOWN);
      power_q    <= (state_nxt == ST_ARMED) || (state_nxt == ST_HOLD);
      fault_q    <= (state_nxt == ST_SHUTDOWN);
    end
  end

  assign io.armed        = armed_q;
  assign io.dac_hold     = dac_hold_q;
  assign io.power_enable = power_q;
  assign io.fault        = fault_q;
  assign io.fault_cause  = cause_q;

`ifdef SHUTDOWN_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (capture)    ts_q <= ts_cnt;
      else if (clear) ts_q <= '0;
    end
  end

  assign io.fault_timestamp = ts_q;
`endif

endmodule

// File: tb/tb_integrator_shutdown_sequencer.sv
// Directed bench for integrator_shutdown_sequencer with HOLD_CYCLES=16.
// Output vector compared is {armed, dac_hold, power_enable, fault, fault_cause}.
module tb_integrator_shutdown_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  integrator_shutdown_sequencer_if bus ();

  integrator_shutdown_sequencer #(.HOLD_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.armed, bus.dac_hold, bus.power_enable, bus.fault, bus.fault_cause};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.enable         = 1'b0;
    bus.setup_done     = 1'b0;
    bus.over_threshold = 1'b0;
    bus.err_overflow   = 1'b0;
    bus.err_underflow  = 1'b0;
    bus.ext_shutdown   = 1'b0;
    bus.fault_clear    = 1'b0;
  endtask

  task automatic arm();
    bus.enable = 1'b1;
    tick();
    bus.setup_done = 1'b1;
    tick();
    bus.setup_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", outs(), 8'b0000_0000);
    end
    rst = 1'b0;
    tick();
    bus.over_threshold = 1'b1;
    tick();
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL idle_ignores_fault got=%b exp=%b", outs(), 8'b0000_0000);
    end
    bus.over_threshold = 1'b0;
    tick();
  endtask

  task automatic test_hold_sequence();
    int bad;
    bus.enable = 1'b1;
    repeat (5) tick();
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL arming_outputs got=%b exp=%b", outs(), 8'b0000_0000);
    end
    bus.setup_done = 1'b1;
    tick();
    bus.setup_done = 1'b0;
    checks++;
    if (outs() !== 8'b1010_0000) begin
      failures++;
      $display("FAIL armed_outputs got=%b exp=%b", outs(), 8'b1010_0000);
    end
    bus.over_threshold = 1'b1;
    tick();
    bus.over_threshold = 1'b0;
    checks++;
    if (outs() !== 8'b0110_0001) begin
      failures++;
      $display("FAIL hold_entry got=%b exp=%b", outs(), 8'b0110_0001);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (outs() !== 8'b0110_0001) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_duration bad_cycles=%0d exp=0 last=%b", bad, outs());
    end
    tick();
    checks++;
    if (outs() !== 8'b0101_0001) begin
      failures++;
      $display("FAIL shutdown_after_16 got=%b exp=%b", outs(), 8'b0101_0001);
    end
    bus.enable      = 1'b0;
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL clear_to_idle got=%b exp=%b", outs(), 8'b0000_0000);
    end
  endtask

  task automatic test_multi_cause();
    arm();
    bus.err_overflow = 1'b1;
    bus.ext_shutdown = 1'b1;
    tick();
    bus.err_overflow = 1'b0;
    bus.ext_shutdown = 1'b0;
    checks++;
    if (outs() !== 8'b0110_1010) begin
      failures++;
      $display("FAIL multi_cause got=%b exp=%b", outs(), 8'b0110_1010);
    end
    bus.err_underflow = 1'b1;
    bus.enable        = 1'b0;
    bus.fault_clear   = 1'b1;
    tick();
    bus.err_underflow = 1'b0;
    bus.fault_clear   = 1'b0;
    checks++;
    if (outs() !== 8'b0110_1010) begin
      failures++;
      $display("FAIL late_source_ignored got=%b exp=%b", outs(), 8'b0110_1010);
    end
    repeat (15) tick();
    checks++;
    if (outs() !== 8'b0101_1010) begin
      failures++;
      $display("FAIL multi_shutdown got=%b exp=%b", outs(), 8'b0101_1010);
    end
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
  endtask

  task automatic test_arming_fault();
    bus.enable = 1'b1;
    tick();
    bus.ext_shutdown = 1'b1;
    tick();
    bus.ext_shutdown = 1'b0;
    checks++;
    if (outs() !== 8'b0101_1000) begin
      failures++;
      $display("FAIL arming_to_shutdown got=%b exp=%b", outs(), 8'b0101_1000);
    end
    bus.enable         = 1'b0;
    bus.over_threshold = 1'b1;
    bus.fault_clear    = 1'b1;
    tick();
    checks++;
    if (outs() !== 8'b0101_1000) begin
      failures++;
      $display("FAIL clear_blocked_by_source got=%b exp=%b", outs(), 8'b0101_1000);
    end
    bus.over_threshold = 1'b0;
    tick();
    bus.fault_clear = 1'b0;
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL clear_after_drop got=%b exp=%b", outs(), 8'b0000_0000);
    end
  endtask

  task automatic test_armed_disable();
    arm();
    bus.enable = 1'b0;
    tick();
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL armed_disable got=%b exp=%b", outs(), 8'b0000_0000);
    end
  endtask

  task automatic test_reset_mid_hold();
    arm();
    bus.over_threshold = 1'b1;
    tick();
    bus.over_threshold = 1'b0;
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 8'b0000_0000) begin
      failures++;
      $display("FAIL async_reset_in_hold got=%b exp=%b", outs(), 8'b0000_0000);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    arm();
    checks++;
    if (outs() !== 8'b1010_0000) begin
      failures++;
      $display("FAIL rearm_after_reset got=%b exp=%b", outs(), 8'b1010_0000);
    end
    bus.enable = 1'b0;
    tick();
  endtask

`ifdef SHUTDOWN_TIMESTAMP_EN
  task automatic test_timestamp_wrap();
    arm();
    force dut.ts_cnt = 32'hFFFF_FFFE;
    #1 release dut.ts_cnt;
    repeat (3) tick();
    bus.over_threshold = 1'b1;
    tick();
    bus.over_threshold = 1'b0;
    checks++;
    if (bus.fault_timestamp !== 32'h0000_0001) begin
      failures++;
      $display("FAIL timestamp_wrap got=%h exp=%h", bus.fault_timestamp, 32'h0000_0001);
    end
    bus.enable = 1'b0;
    repeat (16) tick();
    bus.fault_clear = 1'b1;
    tick();
    bus.fault_clear = 1'b0;
    checks++;
    if (bus.fault_timestamp !== 32'h0000_0000) begin
      failures++;
      $display("FAIL timestamp_clear got=%h exp=%h", bus.fault_timestamp, 32'h0000_0000);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_hold_sequence();
    test_multi_cause();
    test_arming_fault();
    test_armed_disable();
    test_reset_mid_hold();
`ifdef SHUTDOWN_TIMESTAMP_EN
    test_timestamp_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
